// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Round-robin arbiter sharing the register-file write port among
//            NUM_REQ writeback sources, with a registered output stage and a
//            per-register busy scoreboard for decode hazard stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       reserve_valid,
    input  logic [ADDR_W-1:0]          reserve_reg,
    output logic                       regwrite,
    output logic [ADDR_W-1:0]          register_w,
    output logic [DATA_W-1:0]          write_data,
    output logic [(2**ADDR_W)-1:0]     busy
);

    localparam int                   c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                   c_NREG  = 2**ADDR_W;
    localparam logic [c_PTR_W-1:0]   c_LAST  = c_PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   c_ONE   = NUM_REQ'(1);
    localparam logic [c_NREG-1:0]    c_BIT0  = c_NREG'(1);

    logic [c_PTR_W-1:0] r_ptr;
    logic               r_regwrite;
    logic [ADDR_W-1:0]  r_register_w;
    logic [DATA_W-1:0]  r_write_data;
    logic [c_NREG-1:0]  r_busy;

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_hi_pick;
    logic [NUM_REQ-1:0] w_all_pick;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_grant_en;
    logic               w_accept;
    logic               w_win_live;
    logic [c_PTR_W-1:0] w_win_idx;
    logic [c_PTR_W-1:0] w_ptr_next;
    logic [ADDR_W-1:0]  w_win_reg;
    logic [DATA_W-1:0]  w_win_data;
    logic [c_NREG-1:0]  w_set_vec;
    logic [c_NREG-1:0]  w_clr_vec;
    logic [c_NREG-1:0]  w_busy_next;

    // Requesters at or above the pointer take priority over those below it.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
        localparam logic [c_PTR_W-1:0] c_IDX = c_PTR_W'(i);
        assign w_mask[i] = (c_IDX >= r_ptr);
    end

    assign w_hi       = req_valid & w_mask;
    assign w_hi_pick  = w_hi & (~w_hi + c_ONE);
    assign w_all_pick = req_valid & (~req_valid + c_ONE);

    // Gating with reset keeps grants off while the block is held in reset.
    assign w_grant_en = reset & ~stall;
    assign w_grant    = !w_grant_en ? '0 : ((|w_hi) ? w_hi_pick : w_all_pick);
    assign req_ready  = w_grant;
    assign w_accept   = |w_grant;

    always_comb begin
        w_win_idx  = '0;
        w_win_reg  = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_idx  = c_PTR_W'(i);
                w_win_reg  = req_reg[i*ADDR_W +: ADDR_W];
                w_win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_next = (w_win_idx == c_LAST) ? '0 : (w_win_idx + c_PTR_W'(1));
    assign w_win_live = w_accept && (w_win_reg != '0);

    // Set is OR'd in after clear so a fresh reservation beats a retiring write.
    assign w_set_vec   = (reserve_valid && (reserve_reg != '0)) ? (c_BIT0 << reserve_reg) : '0;
    assign w_clr_vec   = w_win_live ? (c_BIT0 << w_win_reg) : '0;
    assign w_busy_next = ((r_busy & ~w_clr_vec) | w_set_vec) & ~c_BIT0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr        <= '0;
            r_regwrite   <= 1'b0;
            r_register_w <= '0;
            r_write_data <= '0;
            r_busy       <= '0;
        end else begin
            r_regwrite <= w_win_live;
            r_busy     <= w_busy_next;
            if (w_accept) begin
                r_ptr        <= w_ptr_next;
                r_register_w <= w_win_reg;
                r_write_data <= w_win_data;
            end
        end
    end

    assign regwrite   = r_regwrite;
    assign register_w = r_register_w;
    assign write_data = r_write_data;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (register_w, write_data, regwrite) between NUM_REQ writeback sources, such as ALU, load unit and multiply/divide unit.
- Uses round-robin arbitration with a valid/ready handshake per source.
- Registers the winning write for one cycle, so the register file samples stable values on its negative-edge write.
- Keeps a per-register busy scoreboard that decode uses for hazard stalls.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
stall  input  1  1 = issue no grants this cycle
req_valid  input  NUM_REQ  requester i has a write pending
req_reg  input  NUM_REQ*ADDR_W  destination index, slice i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  write data, slice i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant, combinational
reserve_valid  input  1  decode reserves a destination register
reserve_reg  input  ADDR_W  register being reserved
regwrite  output  1  to register file write enable
register_w  output  ADDR_W  to register file write index
write_data  output  DATA_W  to register file write data
busy  output  2**ADDR_W  scoreboard; bit r = write to r outstanding

Behaviour:
- Reset (reset=0, async) clears regwrite, register_w, write_data and busy to 0, and sets the round-robin pointer to 0.
- Arbitration is combinational:
  - If stall=0, req_ready[i]=1 for the first i with req_valid[i]=1, searching from ptr upward modulo NUM_REQ. Otherwise req_ready is all 0.
  - At most one req_ready bit is set. req_ready[i] is never 1 while req_valid[i]=0.
- Transfer: a requester is accepted at the posedge where req_valid[i] & req_ready[i].
  - The requester must hold req_reg/req_data stable while valid and not ready.
  - It may deassert valid only after acceptance.
- Pointer update: on acceptance of i, ptr <= (i+1) mod NUM_REQ. Without acceptance, ptr holds.
- Output stage, one cycle latency:
  - On an acceptance posedge, register_w/write_data load the winner's values.
  - regwrite <= 1 only if the winner's req_reg != 0.
  - On any posedge without acceptance, regwrite <= 0; register_w/write_data hold their last value.
  - regwrite is therefore high for exactly one clock per accepted nonzero write. Back-to-back acceptances give consecutive regwrite pulses.
- Register 0: a request to register 0 is arbitrated and accepted normally and advances ptr. It never asserts regwrite and never touches busy.
- Scoreboard, per posedge:
  - Set: busy[reserve_reg] <= 1 if reserve_valid=1, reserve_reg != 0 and stall is don't-care.
  - Clear: busy[req_reg of winner] <= 0 on acceptance, winner's req_reg != 0.
  - Set and clear of the same register in the same cycle: set wins, because a new producer is reserved.
  - Set and clear of different registers both take effect.
  - busy[0] is constant 0.
  - Reserving an already-busy register leaves it busy, with no counting.
  - Clearing a non-busy register is harmless.
- Stall: no grants and ptr frozen while stall=1. The scoreboard still accepts reserves. A regwrite pulse already in the output stage still completes.
- Reset mid-operation:
  - An in-flight regwrite pulse is dropped and busy is cleared.
  - Requesters see req_ready=0 while reset=0.
  - The first grant after reset release goes to the lowest valid index.

Test Plan:
- Reset, then req_valid=3'b001, req_reg0=5, req_data0=32'hDEADBEEF -> req_ready=001 that cycle; next cycle regwrite=1, register_w=5, write_data=DEADBEEF; the following cycle regwrite=0.
- All three valid continuously, regs 1/2/3 -> grants in order 001,010,100,001; regwrite high every cycle with register_w 1,2,3,1.
- req_valid=001 with req_reg0=0 -> req_ready0=1, regwrite stays 0, ptr advances (next simultaneous 011 grants requester 1 first).
- reserve_valid with reg 7 -> busy[7]=1; later requester 2 writes reg 7 -> busy[7]=0 on acceptance edge. Reserve of 7 plus accepted write to 7 in the same cycle -> busy[7] stays 1.
- stall=1 with req_valid=111 for 3 cycles -> req_ready=000 and regwrite=0; stall=0 -> grant resumes from the frozen ptr.
- Assert reset low asynchronously mid-cycle with regwrite=1 and busy nonzero -> regwrite, busy and register_w go 0 immediately, with no clock edge needed.
